// File: rtl/axi_lite_gpio_responder.sv
// AXI4-Lite GPIO register block: DATA/SET/CLR/ID registers driving
// a registered GPIO output, with independent write and read FSMs.
module axi_lite_gpio_responder #(
  parameter int          GPIO_WIDTH       = 8,
  parameter logic [31:0] GPIO_RESET_VALUE = 32'h00,
  parameter logic [31:0] ID_VALUE         = 32'h4750_494F
) (
  input  logic                  clk_300,
  input  logic                  reset,
  input  logic [3:0]            s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [3:0]            s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [GPIO_WIDTH-1:0] gpio_io_o
);

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_SET  = 2'd1;
  localparam logic [1:0] A_CLR  = 2'd2;
  localparam logic [1:0] A_ID   = 2'd3;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic                  aw_got_q, w_got_q;
  logic [1:0]            awaddr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [GPIO_WIDTH-1:0] data_q, data_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic        aw_hs, w_hs, ar_hs, commit;
  logic [1:0]  sel_addr;
  logic [31:0] sel_data, mask, cur32, new32;
  logic [3:0]  sel_strb;

  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid && s_axi_wready;
  assign ar_hs  = s_axi_arvalid && s_axi_arready;
  assign commit = (w_state_q == W_IDLE) && (aw_got_q || aw_hs)
                  && (w_got_q || w_hs);

  // Buffered beats take priority over live bus values
  assign sel_addr = aw_got_q ? awaddr_q : s_axi_awaddr[3:2];
  assign sel_data = w_got_q ? wdata_q : s_axi_wdata;
  assign sel_strb = w_got_q ? wstrb_q : s_axi_wstrb;

  always_ff @(posedge clk_300) begin
    if (reset) w_state_q <= W_IDLE;
    else       w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE: if (commit) w_state_d = W_RESP;
      W_RESP: if (s_axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = (w_state_q == W_IDLE) && !aw_got_q;
    s_axi_wready  = (w_state_q == W_IDLE) && !w_got_q;
    s_axi_bvalid  = (w_state_q == W_RESP);
    s_axi_bresp   = bresp_q;
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{sel_strb[i]}};
    cur32 = '0;
    cur32[GPIO_WIDTH-1:0] = data_q;
    new32   = cur32;
    bresp_d = 2'b00;
    unique case (sel_addr)
      A_DATA: new32 = (cur32 & ~mask) | (sel_data & mask);
      A_SET:  new32 = cur32 | (sel_data & mask);
      A_CLR:  new32 = cur32 & ~(sel_data & mask);
      A_ID:   bresp_d = 2'b10;
      default: new32 = cur32;
    endcase
    data_d = new32[GPIO_WIDTH-1:0];
  end

  always_ff @(posedge clk_300) begin
    if (reset) begin
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      data_q   <= GPIO_RESET_VALUE[GPIO_WIDTH-1:0];
      bresp_q  <= 2'b00;
    end else if (commit) begin
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      data_q   <= data_d;
      bresp_q  <= bresp_d;
    end else begin
      if (aw_hs) begin
        aw_got_q <= 1'b1;
        awaddr_q <= s_axi_awaddr[3:2];
      end
      if (w_hs) begin
        w_got_q <= 1'b1;
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
    end
  end

  assign gpio_io_o = data_q;

  always_ff @(posedge clk_300) begin
    if (reset) r_state_q <= R_IDLE;
    else       r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE: if (s_axi_arvalid) r_state_d = R_DATA;
      R_DATA: if (s_axi_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = (r_state_q == R_IDLE);
    s_axi_rvalid  = (r_state_q == R_DATA);
    s_axi_rdata   = rdata_q;
    s_axi_rresp   = rresp_q;
  end

  always_comb begin
    rdata_d = '0;
    rresp_d = 2'b00;
    unique case (s_axi_araddr[3:2])
      A_DATA: rdata_d[GPIO_WIDTH-1:0] = data_q;
      A_SET:  rresp_d = 2'b10;
      A_CLR:  rresp_d = 2'b10;
      A_ID:   rdata_d = ID_VALUE;
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_300) begin
    if (reset) begin
      rdata_q <= '0;
      rresp_q <= 2'b00;
    end else if (ar_hs) begin
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

  logic unused;
  assign unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], new32};

endmodule

// File: tb/tb_axi_lite_gpio_responder.sv
// Directed bench for axi_lite_gpio_responder: handshake ordering,
// register semantics, back-pressure and mid-transaction reset.
`timescale 1ns/1ps
module tb_axi_lite_gpio_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [7:0]  gpio;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_lite_gpio_responder dut (
    .clk_300       (clk),
    .reset         (reset),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .gpio_io_o     (gpio)
  );

  task automatic do_write(input logic [3:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit rel,
                          output logic [1:0] br, output logic bv);
    @(negedge clk);
    awvalid = 1; awaddr = a; wvalid = 1; wdata = d; wstrb = s;
    @(posedge clk);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    br = bresp; bv = bvalid;
    if (rel) begin
      bready = 1;
      @(posedge clk);
      @(negedge clk);
      bready = 0;
    end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    checks++;
    if (gpio !== 8'h00) begin
      errors++; $display("FAIL rst_gpio got=%h exp=00", gpio);
    end
    checks++;
    if ({bvalid, rvalid} !== 2'b00) begin
      errors++; $display("FAIL rst_valid got=%b exp=00", {bvalid, rvalid});
    end
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++;
      $display("FAIL rst_ready got=%b exp=111", {awready, wready, arready});
    end
    checks++;
    if ({bresp, rresp, rdata} !== 36'h0) begin
      errors++; $display("FAIL rst_resp got=%h exp=0", {bresp, rresp, rdata});
    end
  endtask

  task automatic test_same_cycle;
    logic [1:0] br; logic bv;
    do_write(4'h0, 32'h01, 4'hF, 0, br, bv);
    checks++;
    if (gpio !== 8'h01) begin
      errors++; $display("FAIL same_gpio got=%h exp=01", gpio);
    end
    checks++;
    if ({bv, br} !== 3'b100) begin
      errors++; $display("FAIL same_b got=%b exp=100", {bv, br});
    end
    checks++;
    if ({awready, wready} !== 2'b00) begin
      errors++; $display("FAIL same_rdy got=%b exp=00", {awready, wready});
    end
    bready = 1;
    @(posedge clk);
    @(negedge clk);
    bready = 0;
    checks++;
    if (bvalid !== 1'b0) begin
      errors++; $display("FAIL same_bdone got=%b exp=0", bvalid);
    end
  endtask

  task automatic test_w_first;
    @(negedge clk);
    wvalid = 1; wdata = 32'h02; wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    wvalid = 0;
    checks++;
    if ({wready, awready} !== 2'b01) begin
      errors++; $display("FAIL wfirst_rdy got=%b exp=01", {wready, awready});
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({gpio, bvalid} !== {8'h01, 1'b0}) begin
      errors++; $display("FAIL wfirst_hold got=%h/%b exp=01/0", gpio, bvalid);
    end
    awvalid = 1; awaddr = 4'h0;
    @(posedge clk);
    @(negedge clk);
    awvalid = 0;
    checks++;
    if ({gpio, bvalid} !== {8'h02, 1'b1}) begin
      errors++; $display("FAIL wfirst_commit got=%h/%b exp=02/1", gpio, bvalid);
    end
    bready = 1;
    @(posedge clk);
    @(negedge clk);
    bready = 0;
  endtask

  task automatic test_set_clr;
    logic [1:0] br; logic bv;
    do_write(4'h0, 32'h0F, 4'hF, 1, br, bv);
    do_write(4'h4, 32'hF0, 4'hF, 0, br, bv);
    checks++;
    if (gpio !== 8'hFF) begin
      errors++; $display("FAIL set_gpio got=%h exp=ff", gpio);
    end
    bready = 1; @(posedge clk); @(negedge clk); bready = 0;
    do_write(4'hB, 32'h03, 4'hF, 1, br, bv);
    checks++;
    if (gpio !== 8'hFC) begin
      errors++; $display("FAIL clr_gpio got=%h exp=fc", gpio);
    end
    @(negedge clk);
    arvalid = 1; araddr = 4'h0;
    @(posedge clk);
    @(negedge clk);
    arvalid = 0;
    checks++;
    if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, 32'h0000_00FC}) begin
      errors++;
      $display("FAIL rd_data got=%b/%b/%h exp=1/00/000000fc",
               rvalid, rresp, rdata);
    end
    rready = 1; @(posedge clk); @(negedge clk); rready = 0;
    checks++;
    if (rvalid !== 1'b0) begin
      errors++; $display("FAIL rd_done got=%b exp=0", rvalid);
    end
  endtask

  task automatic test_id;
    logic [1:0] br; logic bv;
    @(negedge clk);
    arvalid = 1; araddr = 4'hE;
    @(posedge clk);
    @(negedge clk);
    arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rvalid, arready, rdata} !== {2'b10, 32'h4750_494F}) begin
        errors++;
        $display("FAIL id_hold%0d got=%b%b/%h exp=10/4750494f",
                 i, rvalid, arready, rdata);
      end
      @(negedge clk);
    end
    rready = 1; @(posedge clk); @(negedge clk); rready = 0;
    checks++;
    if ({rvalid, arready} !== 2'b01) begin
      errors++; $display("FAIL id_done got=%b exp=01", {rvalid, arready});
    end
    arvalid = 1; araddr = 4'h8;
    @(posedge clk); @(negedge clk);
    arvalid = 0;
    checks++;
    if ({rresp, rdata} !== {2'b10, 32'h0}) begin
      errors++; $display("FAIL rd_clr got=%b/%h exp=10/0", rresp, rdata);
    end
    rready = 1; @(posedge clk); @(negedge clk); rready = 0;
    do_write(4'hC, 32'hFF, 4'hF, 1, br, bv);
    checks++;
    if ({br, gpio} !== {2'b10, 8'hFC}) begin
      errors++; $display("FAIL id_wr got=%b/%h exp=10/fc", br, gpio);
    end
  endtask

  task automatic test_strb;
    logic [1:0] br; logic bv;
    do_write(4'h0, 32'hAA, 4'h0, 0, br, bv);
    checks++;
    if ({br, gpio} !== {2'b00, 8'hFC}) begin
      errors++; $display("FAIL strb0 got=%b/%h exp=00/fc", br, gpio);
    end
    awvalid = 1; awaddr = 4'h0; wvalid = 1; wdata = 32'h11; wstrb = 4'hF;
    repeat (3) @(negedge clk);
    checks++;
    if ({bvalid, awready, wready, gpio} !== {3'b100, 8'hFC}) begin
      errors++;
      $display("FAIL bp_hold got=%b%b%b/%h exp=100/fc",
               bvalid, awready, wready, gpio);
    end
    awvalid = 0; wvalid = 0;
    bready = 1; @(posedge clk); @(negedge clk); bready = 0;
    do_write(4'h0, 32'hFF, 4'h2, 1, br, bv);
    checks++;
    if (gpio !== 8'hFC) begin
      errors++; $display("FAIL strb_hi got=%h exp=fc", gpio);
    end
    do_write(4'h0, 32'hFFFF_FF5A, 4'hF, 1, br, bv);
    checks++;
    if (gpio !== 8'h5A) begin
      errors++; $display("FAIL trunc got=%h exp=5a", gpio);
    end
  endtask

  task automatic test_reset_mid;
    logic [1:0] br; logic bv;
    do_write(4'h0, 32'h01, 4'hF, 1, br, bv);
    do_write(4'h0, 32'h55, 4'hF, 0, br, bv);
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    checks++;
    if ({gpio, bvalid} !== {8'h00, 1'b0}) begin
      errors++; $display("FAIL midrst got=%h/%b exp=00/0", gpio, bvalid);
    end
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++;
      $display("FAIL midrst_rdy got=%b exp=111", {awready, wready, arready});
    end
    do_write(4'h0, 32'h02, 4'hF, 1, br, bv);
    checks++;
    if ({bv, br, gpio} !== {3'b100, 8'h02}) begin
      errors++; $display("FAIL post_rst got=%b%b/%h exp=100/02", bv, br, gpio);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    awvalid = 1; awaddr = 4'h0; wvalid = 1; wdata = 32'h33; wstrb = 4'hF;
    arvalid = 1; araddr = 4'h1;
    @(posedge clk);
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    checks++;
    if ({rdata, gpio} !== {32'h02, 8'h33}) begin
      errors++; $display("FAIL rw_same got=%h/%h exp=00000002/33", rdata, gpio);
    end
    bready = 1; rready = 1;
    @(posedge clk); @(negedge clk);
    bready = 0; rready = 0;
    checks++;
    if ({bvalid, rvalid} !== 2'b00) begin
      errors++; $display("FAIL rw_done got=%b exp=00", {bvalid, rvalid});
    end
  endtask

  initial begin
    reset = 1; awaddr = 0; araddr = 0; awvalid = 0; wvalid = 0;
    bready = 0; arvalid = 0; rready = 0; wdata = 0; wstrb = 0;
    test_reset;
    test_same_cycle;
    test_w_first;
    test_set_clr;
    test_id;
    test_strb;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_gpio_responder.md
AXI_LITE_GPIO_RESPONDER -- requirements
Module: axi_lite_gpio_responder

Interface
REQ-001 SHALL have parameter GPIO_WIDTH, default 8, width of gpio_io_o (legal 1..32).
REQ-002 SHALL have parameter GPIO_RESET_VALUE, default 'h00, value loaded into DATA on reset.
REQ-003 SHALL have parameter ID_VALUE, default 32'h4750_494F, constant returned by ID register.
REQ-004 SHALL have port clk_300  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports s_axi_awaddr  input  4, s_axi_awvalid  input  1, s_axi_awready  output  1  write address channel.
REQ-007 SHALL have ports s_axi_wdata  input  32, s_axi_wstrb  input  4, s_axi_wvalid  input  1, s_axi_wready  output  1  write data channel.
REQ-008 SHALL have ports s_axi_bresp  output  2, s_axi_bvalid  output  1, s_axi_bready  input  1  write response channel.
REQ-009 SHALL have ports s_axi_araddr  input  4, s_axi_arvalid  input  1, s_axi_arready  output  1  read address channel.
REQ-010 SHALL have ports s_axi_rdata  output  32, s_axi_rresp  output  2, s_axi_rvalid  output  1, s_axi_rready  input  1  read data channel.
REQ-011 SHALL have port gpio_io_o  output  GPIO_WIDTH  registered GPIO output, equal to DATA.

Function
REQ-012 SHALL decode awaddr/araddr[3:2] only: 0 DATA (rw), 1 SET (wo), 2 CLR (wo), 3 ID (ro); bits [1:0] ignored.
REQ-013 SHALL implement write FSM W_IDLE -> W_RESP -> W_IDLE; read FSM R_IDLE -> R_DATA -> R_IDLE; FSMs independent.
REQ-014 In W_IDLE, awready SHALL be 1 until AW handshake captured, wready 1 until W handshake captured; AW and W accepted in either order or same cycle.
REQ-015 On the cycle both AW and W are captured, SHALL commit write and enter W_RESP; gpio_io_o and bvalid update on the next edge (1-cycle latency from last handshake).
REQ-016 DATA write SHALL replace bits whose byte lane strobe is 1; SET SHALL OR wdata into DATA; CLR SHALL AND ~wdata into DATA; lanes with wstrb=0 unchanged; bits above GPIO_WIDTH discarded.
REQ-017 Write to ID SHALL not change state and SHALL return bresp=2'b10 (SLVERR); all other writes bresp=2'b00.
REQ-018 In W_RESP, awready=wready=0, bvalid=1, bresp stable until bready=1; return to W_IDLE on the handshake edge.
REQ-019 In R_IDLE, arready=1; on AR handshake SHALL register rdata and enter R_DATA (rvalid=1 next edge).
REQ-020 Read data: DATA zero-extended to 32; SET and CLR read 0 with rresp=2'b10; ID reads ID_VALUE; otherwise rresp=2'b00.
REQ-021 In R_DATA, arready=0, rvalid=1, rdata/rresp stable until rready=1; return to R_IDLE on handshake.
REQ-022 Read of DATA accepted in the same cycle as a write commit SHALL return the pre-write value.
REQ-023 SHALL support one outstanding write and one outstanding read at a time; no combinational path from any input to any output.

Reset
REQ-024 On reset=1 at a clock edge, SHALL set both FSMs to idle, discard captured AW/W, and drive gpio_io_o=GPIO_RESET_VALUE, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
REQ-025 Reset mid-transaction SHALL abandon the transaction without a response; awready/wready/arready SHALL be 1 the first cycle after reset deasserts.

Verification
REQ-026 Reset then write DATA 'h01, wstrb 'hF, AW and W same cycle -> gpio_io_o='h01 and bvalid=1, bresp=0 one cycle later.
REQ-027 W sent 3 cycles before AW (DATA 'h02) -> wready drops after W handshake, no commit until AW; gpio_io_o='h02 one cycle after AW handshake.
REQ-028 DATA='h0F, write SET 'hF0 then CLR 'h03 -> gpio_io_o='hFF then 'hFC; read DATA returns 32'h0000_00FC, rresp=0.
REQ-029 Read ID with rready held 0 for 5 cycles -> rvalid=1, rdata=32'h4750_494F stable, arready=0 until rready handshake; write to ID -> bresp=2'b10, gpio_io_o unchanged.
REQ-030 Write DATA 'hAA with wstrb 'h0 -> gpio_io_o unchanged, bresp=0; bready held 0 -> bvalid stays 1, next AW not accepted.
REQ-031 DATA='h01, assert reset 1 cycle during W_RESP -> gpio_io_o='h00, bvalid=0 next cycle; subsequent write 'h02 completes normally.
